// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a framed byte stream, writes
// big-endian words to consecutive addresses and holds the CPU in reset until done.
module imem_loader #(
  parameter logic [31:0] ADDR_BASE = 32'd0,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clka,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t      state;
  state_t      state_next;
  logic [7:0]  n_hi;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [23:0] word_sr;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic [31:0] next_addr;
  logic [15:0] hdr_n;
  logic        xfer;
  logic        last_byte_of_word;
  logic        last_word;

  // Handshake and status outputs are pure decodes of the state register.
  assign in_ready  = (state == HDR_HI) || (state == HDR_LO) ||
                     (state == DATA)   || (state == CSUM);
  assign cpu_reset = (state != DONE);
  assign done      = (state == DONE);
  assign err       = (state == ERR);

  assign xfer              = in_valid && in_ready;
  assign hdr_n             = {n_hi, in_data};
  assign last_byte_of_word = (byte_idx == 2'd3);
  assign last_word         = (word_idx == n_words - 16'd1);

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   state_next = HDR_HI;
      HDR_HI: if (xfer) state_next = HDR_LO;
      HDR_LO: begin
        if (xfer) begin
          if ({16'd0, hdr_n} > MAX_W) begin
            state_next = ERR;
          end else if (hdr_n == 16'd0) begin
            state_next = CSUM;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (xfer && last_byte_of_word && last_word) begin
          state_next = CSUM;
        end
      end
      CSUM: begin
        if (xfer) begin
          state_next = (in_data == csum) ? DONE : ERR;
        end
      end
      DONE:    state_next = DONE;
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: header latch, word assembly, checksum and the registered write port.
  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      n_hi         <= 8'd0;
      n_words      <= 16'd0;
      word_idx     <= 16'd0;
      word_sr      <= 24'd0;
      byte_idx     <= 2'd0;
      csum         <= 8'd0;
      next_addr    <= ADDR_BASE;
      im_we        <= 1'b0;
      im_addr      <= ADDR_BASE;
      im_wdata     <= 32'd0;
      words_loaded <= 16'd0;
    end else begin
      im_we <= 1'b0;
      if (im_we) begin
        words_loaded <= words_loaded + 16'd1;
      end
      case (state)
        HDR_HI: begin
          if (xfer) begin
            n_hi <= in_data;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            n_words <= hdr_n;
          end
        end
        DATA: begin
          if (xfer) begin
            word_sr  <= {word_sr[15:0], in_data};
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (last_byte_of_word) begin
              im_we     <= 1'b1;
              im_addr   <= next_addr;
              im_wdata  <= {word_sr, in_data};
              next_addr <= next_addr + 32'd4;
              word_idx  <= word_idx + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: good, bad-checksum, empty,
// oversize, stalled and mid-load-reset frames with hand-computed expectations.
module tb_imem_loader;

  logic        clka = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;
  int ready_violations = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  frame[$];

  imem_loader #(.ADDR_BASE(32'd0), .MAX_WORDS(256)) dut (
    .clka         (clka),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clka = ~clka;

  // Observe the write port and the ready rule mid-cycle.
  always @(negedge clka) begin
    if (im_we) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
    end
    if (in_ready && (done || err)) begin
      ready_violations++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clka);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clka);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Called at a negedge; returns at the negedge right after the transfer edge.
  task automatic sendByte(input logic [7:0] b, input bit stall);
    int guard = 0;
    int gaps = 0;
    if (stall) begin
      while ($urandom_range(0, 1) == 1 && gaps < 8) begin
        in_valid = 1'b0;
        @(negedge clka);
        gaps++;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 20) begin
      @(negedge clka);
      guard++;
    end
    if (!in_ready) begin
      checkOutput("ready_timeout", 32'(in_ready), 32'd1);
    end
    @(negedge clka);
  endtask

  // Sends the first `count` bytes of frame; also checks each word's write
  // strobe appears in the cycle after its 4th byte.
  task automatic applyStimulus(input int count, input bit stall);
    int n;
    n = 0;
    if (frame.size() >= 2) n = {frame[0], frame[1]};
    for (int i = 0; i < count; i++) begin
      sendByte(frame[i], stall);
      if (i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3 && n <= 256) begin
        checkOutput($sformatf("we_after_byte%0d", i), 32'(im_we), 32'd1);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic loadGoodFrame();
    frame = '{8'h00, 8'h02, 8'h20, 8'h00, 8'h00, 8'h05,
              8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC};
  endtask

  task automatic checkGoodResult(input string pfx);
    checkOutput({pfx, "_wr_count"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      checkOutput({pfx, "_addr0"}, wr_addr[0], 32'h0000_0000);
      checkOutput({pfx, "_data0"}, wr_data[0], 32'h2000_0005);
      checkOutput({pfx, "_addr1"}, wr_addr[1], 32'h0000_0004);
      checkOutput({pfx, "_data1"}, wr_data[1], 32'h8C01_0004);
    end
    checkOutput({pfx, "_words_loaded"}, 32'(words_loaded), 32'd2);
    checkOutput({pfx, "_done"}, 32'(done), 32'd1);
    checkOutput({pfx, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    checkOutput({pfx, "_err"}, 32'(err), 32'd0);
    checkOutput({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    // Reset state
    #3;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_im_we", 32'(im_we), 32'd0);
    checkOutput("rst_im_addr", im_addr, 32'd0);
    checkOutput("rst_im_wdata", im_wdata, 32'd0);
    checkOutput("rst_words_loaded", 32'(words_loaded), 32'd0);

    // Good 2-word frame, back-to-back
    doReset();
    loadGoodFrame();
    applyStimulus(11, 1'b0);
    checkGoodResult("good");
    repeat (3) @(negedge clka);
    checkOutput("good_done_sticky", 32'(done), 32'd1);

    // Bad checksum
    doReset();
    loadGoodFrame();
    frame[10] = 8'hAD;
    applyStimulus(11, 1'b0);
    checkOutput("badcs_wr_count", 32'(wr_addr.size()), 32'd2);
    checkOutput("badcs_err", 32'(err), 32'd1);
    checkOutput("badcs_done", 32'(done), 32'd0);
    checkOutput("badcs_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("badcs_in_ready", 32'(in_ready), 32'd0);

    // Empty frame, good and bad checksum
    doReset();
    frame = '{8'h00, 8'h00, 8'h00};
    applyStimulus(3, 1'b0);
    checkOutput("empty_wr_count", 32'(wr_addr.size()), 32'd0);
    checkOutput("empty_done", 32'(done), 32'd1);
    checkOutput("empty_cpu_reset", 32'(cpu_reset), 32'd0);
    doReset();
    frame = '{8'h00, 8'h00, 8'h01};
    applyStimulus(3, 1'b0);
    checkOutput("empty_bad_err", 32'(err), 32'd1);
    checkOutput("empty_bad_done", 32'(done), 32'd0);

    // Oversize header (N = 257)
    doReset();
    frame = '{8'h01, 8'h01};
    applyStimulus(2, 1'b0);
    checkOutput("over_err", 32'(err), 32'd1);
    checkOutput("over_in_ready", 32'(in_ready), 32'd0);
    repeat (4) @(negedge clka);
    checkOutput("over_wr_count", 32'(wr_addr.size()), 32'd0);

    // Stalled source
    doReset();
    loadGoodFrame();
    applyStimulus(11, 1'b1);
    checkGoodResult("stall");

    // Mid-load reset after 6 bytes, then full frame
    doReset();
    loadGoodFrame();
    applyStimulus(6, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("midrst_im_we", 32'(im_we), 32'd0);
    checkOutput("midrst_im_addr", im_addr, 32'd0);
    checkOutput("midrst_im_wdata", im_wdata, 32'd0);
    checkOutput("midrst_words_loaded", 32'(words_loaded), 32'd0);
    @(negedge clka);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    applyStimulus(11, 1'b0);
    checkGoodResult("midrst");

    checkOutput("ready_outside_rx", 32'(ready_violations), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory of the KGP RISC processor. It is the writer side of the instruction-memory interface that the processor only reads. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to consecutive word addresses. It holds the processor in reset (`cpu_reset`) until a complete frame with a correct checksum has been stored.

## Interface

**Parameters**
- `ADDR_BASE`, default 32'd0: byte address of the first instruction word.
- `MAX_WORDS`, default 256: largest accepted word count; equals the instruction memory depth.

**Ports**
- `clka`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: source presents a byte on `in_data`.
- `in_data`, input, 8: stream byte.
- `in_ready`, output, 1: loader can accept a byte this cycle.
- `im_we`, output, 1: one-cycle write strobe to instruction memory; drives all four byte enables.
- `im_addr`, output, 32: byte address of the write; always a multiple of 4.
- `im_wdata`, output, 32: instruction word to write.
- `cpu_reset`, output, 1: holds the processor's program counter in reset while high.
- `done`, output, 1: load completed successfully; sticky.
- `err`, output, 1: frame rejected; sticky.
- `words_loaded`, output, 16: number of words written so far.

## Operation

**Frame format:** `N[15:8]`, `N[7:0]`, then 4·N data bytes (each word MSB first), then one checksum byte. The checksum is the XOR of all data bytes (header excluded), so N = 0 requires a checksum of 0x00.

**Byte transfer:** a byte transfers on a rising `clka` edge where `in_valid && in_ready`.

**States:** IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR.
- IDLE → HDR_HI unconditionally on the next edge.
- HDR_HI: on transfer, latch `N[15:8]` → HDR_LO.
- HDR_LO: on transfer, latch `N[7:0]`, then branch on the full 16-bit N:
  - N > `MAX_WORDS` → ERR.
  - N = 0 → CSUM.
  - otherwise → DATA.
- DATA: each transfer shifts the byte into the word assembler (`word <= {word[23:0], in_data}`), XORs it into the checksum accumulator, and increments a 2-bit byte index.
  - On the 4th byte of a word, a write is issued (see Timing).
  - After the 4th byte of word N−1 → CSUM.
- CSUM: on transfer, go to DONE if the byte equals the accumulator, otherwise ERR.
- DONE and ERR are terminal; only `reset` leaves them.

**State-dependent outputs:**
- `in_ready` = 1 only in HDR_HI, HDR_LO, DATA and CSUM; it is decoded from the state register.
- `cpu_reset` = 1 in every state except DONE.
- `done` = 1 in DONE; `err` = 1 in ERR.

**Writes:** word k (0-based) is written to `im_addr` = `ADDR_BASE` + 4·k, computed with 32-bit wrap-around. `words_loaded` increments on each `im_we` pulse.

**Reset behaviour:**
- Reset values: state = IDLE, `in_ready` 0, `im_we` 0, `im_addr` = `ADDR_BASE`, `im_wdata` 0, `cpu_reset` 1, `done` 0, `err` 0, `words_loaded` 0, accumulator 0, byte index 0.
- Reset asserted mid-frame aborts immediately and restarts at IDLE. Words already written to memory are not cleared.

## Timing

- **Handshake:** `in_valid` may drop between bytes (gaps of any length); the loader only advances on a transfer.
- **Write latency:** `im_we`, `im_addr` and `im_wdata` are registered. They are valid for exactly one cycle, the cycle after the edge that accepts the 4th byte of the word.
- **Throughput:** `in_ready` stays high during the write cycle, so back-to-back bytes sustain 1 byte/cycle (one word per 4 cycles). The write never collides with the next word's write.
- **Last word:** the write for the final word occurs in the first cycle of CSUM. The checksum byte may transfer in that same cycle.
- **Release:** `cpu_reset` falls and `done` rises on the edge after the checksum transfer. The processor's first fetch therefore sees all words written.
- **Minimum frame duration:** 1 (IDLE) + 2 + 4·N + 1 transfer cycles.

## Test plan

- **Good 2-word frame:** stream 00 02 20 00 00 05 8C 01 00 04 AC, back-to-back.
  - `im_we` pulses twice: (addr 0x0, data 0x20000005) and (addr 0x4, data 0x8C010004).
  - `words_loaded` = 2, `done` = 1, `cpu_reset` = 0, `err` = 0.
- **Bad checksum:** same frame with last byte 0xAD.
  - Both writes still occur; `err` = 1, `done` = 0, `cpu_reset` stays 1, `in_ready` = 0 afterwards.
- **Empty frame:** stream 00 00 00.
  - No `im_we` pulse; `done` = 1. Repeating with 00 00 01 gives `err` = 1.
- **Oversize frame:** header 01 01 (N = 257) with `MAX_WORDS` = 256.
  - `err` = 1 on the edge after the second header byte; no writes; `in_ready` = 0.
- **Stalled source:** the good frame with `in_valid` randomly low 50% of cycles.
  - Identical writes and final state; `in_ready` is never high outside the receiving states.
- **Mid-load reset:** pulse `reset` after 6 bytes of the good frame, then send the full frame.
  - Outputs return to their reset values asynchronously.
  - The re-sent frame completes with writes at 0x0 and 0x4 and `done` = 1.
